rtype_exec_ctrl: RTL and testbench

RTYPE_EXEC_CTRL -- requirements
Module: rtype_exec_ctrl

---
 rtl/rtype_exec_ctrl.sv | 132 +++++++++++++
 tb/tb_rtype_exec_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rtype_exec_ctrl.sv
// rtype_exec_ctrl: four-cycle R-type controller (register read, ALU, writeback).
// decode_reg_inst splits the latched instruction into register fields and an ALU code.
`ifndef ALU_NOP
`define ADD     5'd0
`define SUB     5'd1
`define SLL     5'd2
`define SLT     5'd3
`define SLTU    5'd4
`define XOR     5'd5
`define SRL     5'd6
`define SRA     5'd7
`define OR      5'd8
`define AND     5'd9
`define ALU_NOP 5'd31
`endif

module decode_reg_inst (
   input  logic [24:0] instr_i,
   output logic [4:0]  rs1_o,
   output logic [4:0]  rs2_o,
   output logic [4:0]  rd_o,
   output logic [4:0]  alu_ctrl_o
);
   logic [6:0] f7;
   logic [2:0] f3;
   // instr_i is instr[31:7], so every field sits 7 bits lower
   assign f7    = instr_i[24:18];
   assign rs2_o = instr_i[17:13];
   assign rs1_o = instr_i[12:8];
   assign f3    = instr_i[7:5];
   assign rd_o  = instr_i[4:0];
   always_comb begin
      alu_ctrl_o = `ALU_NOP;
      if (f7 == 7'h00)
         case (f3)
            3'd0: alu_ctrl_o = `ADD;
            3'd1: alu_ctrl_o = `SLL;
            3'd2: alu_ctrl_o = `SLT;
            3'd3: alu_ctrl_o = `SLTU;
            3'd4: alu_ctrl_o = `XOR;
            3'd5: alu_ctrl_o = `SRL;
            3'd6: alu_ctrl_o = `OR;
            default: alu_ctrl_o = `AND;
         endcase
      else if (f7 == 7'h20)
         alu_ctrl_o = (f3 == 3'd0) ? `SUB : (f3 == 3'd5) ? `SRA : `ALU_NOP;
   end
endmodule

module rtype_exec_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_valid,
   input  logic [31:0] instr,
   output logic        instr_ready,
   output logic [4:0]  rf_raddr1,
   output logic [4:0]  rf_raddr2,
   input  logic [31:0] rf_rdata1,
   input  logic [31:0] rf_rdata2,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [4:0]  alu_ctrl,
   input  logic [31:0] alu_result,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   input  logic        wb_stall,
   output logic        illegal,
   input  logic        trap_ack,
   output logic [15:0] retire_cnt
);
   typedef enum logic [2:0] {IDLE, READ, EXEC, WB, TRAP} state_t;
   state_t      state_q, state_d;
   logic [31:0] instr_q, wdata_q;
   logic [4:0]  waddr_q;
   logic [15:0] retire_q;
   logic [4:0]  rs1, rs2, rd, code;
   logic        rd_phase, ex;

   decode_reg_inst u_dec (
      .instr_i    (instr_q[31:7]),
      .rs1_o      (rs1),
      .rs2_o      (rs2),
      .rd_o       (rd),
      .alu_ctrl_o (code)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         instr_q  <= '0;
         wdata_q  <= '0;
         waddr_q  <= '0;
         retire_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && instr_valid) instr_q <= instr;
         if (state_q == EXEC) begin
            wdata_q <= alu_result;
            waddr_q <= rd;
         end
         if (state_q == WB && !wb_stall) retire_q <= retire_q + 16'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (instr_valid) state_d = READ;
         READ:    state_d = (instr_q[6:0] != 7'h33 || code == `ALU_NOP) ? TRAP : EXEC;
         EXEC:    state_d = WB;
         WB:      if (!wb_stall) state_d = IDLE;
         TRAP:    if (trap_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // read addresses stay up through EXEC so rdata lines up with the operand cycle
   assign rd_phase    = (state_q == READ) || (state_q == EXEC);
   assign ex          = (state_q == EXEC);
   assign instr_ready = (state_q == IDLE);
   assign rf_raddr1   = rd_phase ? rs1 : 5'd0;
   assign rf_raddr2   = rd_phase ? rs2 : 5'd0;
   assign alu_a       = ex ? rf_rdata1 : 32'd0;
   assign alu_b       = ex ? rf_rdata2 : 32'd0;
   assign alu_ctrl    = ex ? code : `ALU_NOP;
   assign rf_we       = (state_q == WB) && !wb_stall && (waddr_q != 5'd0);
   assign rf_waddr    = waddr_q;
   assign rf_wdata    = wdata_q;
   assign illegal     = (state_q == TRAP);
   assign retire_cnt  = retire_q;
endmodule

// File: tb/tb_rtype_exec_ctrl.sv
// tb_rtype_exec_ctrl: directed vectors for the R-type execute controller.
module tb_rtype_exec_ctrl;
   localparam logic [4:0] ADD_C = 5'd0;
   localparam logic [4:0] SUB_C = 5'd1;
   localparam logic [4:0] NOP_C = 5'd31;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic [31:0] instr = '0;
   logic        instr_ready;
   logic [4:0]  rf_raddr1, rf_raddr2;
   logic [31:0] rf_rdata1 = '0, rf_rdata2 = '0;
   logic [31:0] alu_a, alu_b, alu_result;
   logic [4:0]  alu_ctrl;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        wb_stall = 1'b0;
   logic        illegal;
   logic        trap_ack = 1'b0;
   logic [15:0] retire_cnt;
   logic [15:0] exp_ret = '0;
   int          n_tests = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   assign alu_result = (alu_ctrl == SUB_C) ? alu_a - alu_b :
                       (alu_ctrl == ADD_C) ? alu_a + alu_b : 32'd0;

   rtype_exec_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .rf_raddr1   (rf_raddr1),
      .rf_raddr2   (rf_raddr2),
      .rf_rdata1   (rf_rdata1),
      .rf_rdata2   (rf_rdata2),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_ctrl    (alu_ctrl),
      .alu_result  (alu_result),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .wb_stall    (wb_stall),
      .illegal     (illegal),
      .trap_ack    (trap_ack),
      .retire_cnt  (retire_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic [31:0] ins, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [4:0] ctrl, input logic [4:0] waddr, input logic [31:0] wdata,
                         input int n_stall);
      instr = ins;
      instr_valid = 1'b1;
      rf_rdata1 = d1;
      rf_rdata2 = d2;
      chk("idle_ready", instr_ready, 1);
      chk("idle_raddr1", rf_raddr1, 0);
      step;
      instr_valid = 1'b0;
      instr = 32'hFFFF_FFFF;
      wb_stall = (n_stall > 0);
      chk("read_ready", instr_ready, 0);
      chk("read_raddr1", rf_raddr1, ins[19:15]);
      chk("read_raddr2", rf_raddr2, ins[24:20]);
      chk("read_alu_ctrl", alu_ctrl, NOP_C);
      step;
      chk("exec_alu_a", alu_a, d1);
      chk("exec_alu_b", alu_b, d2);
      chk("exec_alu_ctrl", alu_ctrl, ctrl);
      chk("exec_we", rf_we, 0);
      step;
      for (int i = 0; i < n_stall; i++) begin
         chk("stall_we", rf_we, 0);
         chk("stall_wdata", rf_wdata, wdata);
         chk("stall_waddr", rf_waddr, waddr);
         step;
      end
      wb_stall = 1'b0;
      #1;
      chk("wb_we", rf_we, waddr != 5'd0);
      chk("wb_waddr", rf_waddr, waddr);
      chk("wb_wdata", rf_wdata, wdata);
      chk("wb_alu_a", alu_a, 0);
      chk("wb_retire", retire_cnt, exp_ret);
      step;
      exp_ret++;
      chk("post_we", rf_we, 0);
      chk("post_retire", retire_cnt, exp_ret);
      chk("post_ready", instr_ready, 1);
   endtask

   task automatic run_trap(input logic [31:0] ins);
      instr = ins;
      instr_valid = 1'b1;
      step;
      instr_valid = 1'b0;
      chk("trap_read_illegal", illegal, 0);
      step;
      chk("trap_illegal", illegal, 1);
      chk("trap_we", rf_we, 0);
      step;
      chk("trap_hold", illegal, 1);
      chk("trap_ready", instr_ready, 0);
      chk("trap_retire", retire_cnt, exp_ret);
      trap_ack = 1'b1;
      step;
      trap_ack = 1'b0;
      chk("ack_illegal", illegal, 0);
      chk("ack_ready", instr_ready, 1);
      chk("ack_retire", retire_cnt, exp_ret);
   endtask

   initial begin
      step;
      step;
      chk("rst_ready", instr_ready, 1);
      chk("rst_we", rf_we, 0);
      chk("rst_illegal", illegal, 0);
      chk("rst_retire", retire_cnt, 0);
      chk("rst_alu_ctrl", alu_ctrl, NOP_C);
      chk("rst_wdata", rf_wdata, 0);
      rst_n = 1'b1;
      step;
      chk("rel_we", rf_we, 0);
      run_op(32'h002081B3, 32'd5, 32'd7, ADD_C, 5'd3, 32'd12, 0);
      run_op(32'h407302B3, 32'd3, 32'd5, SUB_C, 5'd5, 32'hFFFF_FFFE, 0);
      run_trap(32'hFE2081B3);
      run_trap(32'h002081B7);
      run_op(32'h00208033, 32'd5, 32'd7, ADD_C, 5'd0, 32'd12, 0);
      run_op(32'h002081B3, 32'd100, 32'd23, ADD_C, 5'd3, 32'd123, 3);
      instr = 32'h002081B3;
      instr_valid = 1'b1;
      rf_rdata1 = 32'd5;
      rf_rdata2 = 32'd7;
      step;
      instr_valid = 1'b0;
      wb_stall = 1'b1;
      step;
      step;
      chk("rststall_we", rf_we, 0);
      chk("rststall_wdata", rf_wdata, 32'd12);
      rst_n = 1'b0;
      step;
      exp_ret = '0;
      chk("rststall_ready", instr_ready, 1);
      chk("rststall_we0", rf_we, 0);
      chk("rststall_waddr", rf_waddr, 0);
      chk("rststall_wdata0", rf_wdata, 0);
      chk("rststall_retire", retire_cnt, 0);
      chk("rststall_raddr", rf_raddr1, 0);
      rst_n = 1'b1;
      wb_stall = 1'b0;
      step;
      chk("rststall_rel_we", rf_we, 0);
      force dut.retire_q = 16'hFFFF;
      step;
      release dut.retire_q;
      step;
      exp_ret = 16'hFFFF;
      chk("preload_retire", retire_cnt, 16'hFFFF);
      run_op(32'h002081B3, 32'd1, 32'd1, ADD_C, 5'd3, 32'd2, 0);
      chk("wrap_retire", retire_cnt, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
